// File: rtl/crc_stream_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_pkg
// Description : Shared types, constants and bit-reflection helpers for the
//               parametrised CRC stream engine.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

  // Width of the per-frame word counter (saturating)
  localparam int CNT_W = 16;

  // Commonly used generator polynomials (implicit top bit omitted)
  localparam logic [15:0] CRC16_CCITT = 16'h1021;
  localparam logic [15:0] CRC16_IBM   = 16'h8005;
  localparam logic [31:0] CRC32       = 32'h04C11DB7;

  // Frame FSM: waiting for sop, accumulating a frame, holding a result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Bit-reverse one byte
  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Bit-reverse the low w bits of v; bits at and above w are returned as 0
  function automatic logic [31:0] reflect_crc(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc_stream_engine_step.sv
`default_nettype none
// ============================================================================
// Module      : crc_step
// Description : Combinational CRC update over one DATA_W-bit word. Bytes are
//               consumed most-significant byte first; each byte is optionally
//               bit-reflected before being shifted in MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_step
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 16,
  parameter int               DATA_W = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h1021),
  parameter bit               REFIN  = 1'b0
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  localparam int NBYTES = DATA_W / 8;

  logic [CRC_W-1:0] c;
  logic [7:0]       b;
  logic             fb;

  // Unrolled bit-serial LFSR: every byte of the word in one cycle
  always_comb begin
    c  = crc_i;
    b  = '0;
    fb = 1'b0;
    for (int k = NBYTES - 1; k >= 0; k--) begin
      b = data_i[k*8 +: 8];
      if (REFIN) b = reflect8(b);
      for (int j = 7; j >= 0; j--) begin
        fb = c[CRC_W-1] ^ b[j];
        c  = {c[CRC_W-2:0], 1'b0};
        if (fb) c = c ^ POLY;
      end
    end
    crc_o = c;
  end

endmodule
`default_nettype wire

// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
// Module      : crc_stream_engine
// Description : Frame-based CRC engine with valid/ready input and a held,
//               back-pressurable result. Optional macro CRC_CHECK_EN adds a
//               residue comparator and the o_crc_ok output.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter int               DATA_W  = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(16'hFFFF),
  parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(16'h0000),
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0
`ifdef CRC_CHECK_EN
  ,
  parameter logic [CRC_W-1:0] RESIDUE = '0
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_din_sop,
  input  logic              i_din_eop,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic [CRC_W-1:0]  o_dout,
  output logic [CNT_W-1:0]  o_word_cnt,
`ifdef CRC_CHECK_EN
  output logic              o_crc_ok,
`endif
  output logic              o_busy
);

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] dout_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             w_accept;
  logic             w_load;
  logic [CRC_W-1:0] w_seed;
  logic [CRC_W-1:0] w_step;
  logic [CRC_W-1:0] w_result;
  logic [CNT_W-1:0] w_cnt_inc;

  assign o_din_ready  = (state_q != HOLD);
  assign o_dout_valid = (state_q == HOLD);
  assign o_busy       = (state_q != IDLE);
  assign o_dout       = dout_q;
  assign o_word_cnt   = word_cnt_q;
  assign w_accept     = i_din_valid & o_din_ready;

  // A sop word always starts from the seed, aborting any partial frame
  assign w_seed    = i_din_sop ? INIT : crc_q;
  assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  crc_step #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY),
    .REFIN  (REFIN)
  ) u_step (
    .crc_i  (w_seed),
    .data_i (i_din),
    .crc_o  (w_step)
  );

  // Next-state, CRC and counter update; w_load marks entry into HOLD
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    w_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept && i_din_sop) begin
          crc_d   = w_step;
          cnt_d   = CNT_W'(1);
          state_d = i_din_eop ? HOLD : ACCUM;
          w_load  = i_din_eop;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          crc_d = w_step;
          cnt_d = i_din_sop ? CNT_W'(1) : w_cnt_inc;
          if (i_din_eop) begin
            state_d = HOLD;
            w_load  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (i_dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output transform: optional whole-register reflection, then final XOR
  always_comb begin
    w_result = (REFOUT ? CRC_W'(reflect_crc(32'(crc_d), CRC_W)) : crc_d) ^ XOR_OUT;
  end

  // FSM, running CRC and running word count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result registers, captured once per frame and stable throughout HOLD
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dout_q     <= '0;
      word_cnt_q <= '0;
    end else if (w_load) begin
      dout_q     <= w_result;
      word_cnt_q <= cnt_d;
    end
  end

`ifdef CRC_CHECK_EN
  logic crc_ok_q;
  assign o_crc_ok = crc_ok_q;

  // Residue check on the raw register, before reflection and final XOR
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_ok_q <= 1'b0;
    end else if (w_load) begin
      crc_ok_q <= (crc_d == RESIDUE);
    end
  end
`endif

endmodule
`default_nettype wire
